// File: rtl/kronos_mem_responder_if.sv
// Kronos req/gnt memory port bundle.
// Initiator drives the request side, the responder drives grant and response.
interface kronos_mem_responder_if;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic [31:0] strb_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        err_o;

  modport master (
    output req_i, addr_i, we_i, wdata_i, strb_i,
    input  gnt_o, rdata_o, rvalid_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, wdata_i, strb_i,
    output gnt_o, rdata_o, rvalid_o, err_o
  );
endinterface

// File: rtl/kronos_mem_responder.sv
// Word-addressed memory responder with optional pseudo-random grant stalls.
// Define KRONOS_MEM_RESP_STALL_EN to enable LFSR-driven wait states.
module kronos_mem_responder #(
  parameter int unsigned Depth     = 1 << 20,
  parameter logic [31:0] BaseAddr  = 32'h8000_0000,
  parameter int unsigned StallBits = 2,
  parameter logic [15:0] LfsrSeed  = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  kronos_mem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(Depth);

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic        gnt;
  logic        acc;
  logic [31:0] off;
  logic [31:0] idx;
  logic        in_range;
  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic        err_q;
  logic [31:0] mem [Depth];

  assign off      = bus.addr_i - BaseAddr;
  assign idx      = off >> 2;
  assign in_range = idx < 32'(Depth);

`ifdef KRONOS_MEM_RESP_STALL_EN
  localparam logic [15:0] Seed = (LfsrSeed == 16'h0) ? 16'h0001 : LfsrSeed;

  logic [15:0]          lfsr_q;
  logic [StallBits-1:0] cnt_q, cnt_d;
  logic [StallBits-1:0] stall_s;

  assign stall_s = lfsr_q[StallBits-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
      cnt_q  <= '0;
    end else begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
      cnt_q  <= cnt_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
`ifdef KRONOS_MEM_RESP_STALL_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE, RESP: begin
        if (bus.req_i) begin
`ifdef KRONOS_MEM_RESP_STALL_EN
          if (stall_s == '0) begin
            gnt     = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = stall_s;
            state_d = STALL;
          end
`else
          gnt     = 1'b1;
          state_d = RESP;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef KRONOS_MEM_RESP_STALL_EN
      STALL: begin
        // a dropped request abandons the access without a response
        if (!bus.req_i) begin
          state_d = IDLE;
        end else if (cnt_q == StallBits'(1)) begin
          gnt     = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - StallBits'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // no grant (and hence no memory write) while reset is held
  assign acc        = gnt & rst_ni;
  assign bus.gnt_o  = acc;
  assign bus.rdata_o  = rdata_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.err_o    = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= acc;
      if (acc) begin
        rdata_q <= (!bus.we_i && in_range) ? mem[idx[AW-1:0]] : '0;
        err_q   <= !in_range;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc && bus.we_i && in_range) begin
      mem[idx[AW-1:0]] <= (mem[idx[AW-1:0]] & ~bus.strb_i)
                        | (bus.wdata_i & bus.strb_i);
    end
  end

endmodule
